// File: rtl/dram_arbiter_if.sv
// dram_arbiter_if: core port, debug port and RAM-side bundle of the
// data RAM arbiter; slave = arbiter view, master = requesters + RAM.
interface dram_arbiter_if #(
    parameter int AW = 32
);
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [31:0]   c_wdata;
    logic [2:0]    c_ubhw;
    logic          c_gnt;
    logic          c_rvalid;
    logic [31:0]   c_rdata;
    logic          core_stall;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [2:0]    d_ubhw;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_din;
    logic [2:0]    ram_ubhw;
    logic [31:0]   ram_dout;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata, c_ubhw,
        output c_gnt, c_rvalid, c_rdata, core_stall,
        input  d_req, d_we, d_addr, d_wdata, d_ubhw,
        output d_gnt, d_rvalid, d_rdata,
        output ram_we, ram_addr, ram_din, ram_ubhw,
        input  ram_dout
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata, c_ubhw,
        input  c_gnt, c_rvalid, c_rdata, core_stall,
        output d_req, d_we, d_addr, d_wdata, d_ubhw,
        input  d_gnt, d_rvalid, d_rdata,
        input  ram_we, ram_addr, ram_din, ram_ubhw,
        output ram_dout
    );
endinterface

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the single-port data RAM between the MEM stage (C)
// and a debug/loader master (D); one access per clock, reads return 1 cycle later.
module dram_arbiter #(
    parameter int AW       = 32,
    parameter int MAX_WAIT = 3,
    parameter int CW       = 4
) (
    input logic           clk,
    input logic           rst,
    dram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    localparam logic [CW-1:0] LP_MAX = CW'(MAX_WAIT);

    logic [CW-1:0] r_wait_cnt;
    logic [CW-1:0] w_wait_nxt;
    owner_t        r_owner;
    owner_t        w_owner_nxt;
    logic          w_c_gnt;
    logic          w_d_gnt;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [31:0]   w_din;
    logic [2:0]    w_ubhw;

    // D wins when the core is idle or D has been starved for MAX_WAIT cycles
    always_comb begin
        w_d_gnt = bus.d_req & (~bus.c_req | (r_wait_cnt == LP_MAX));
        w_c_gnt = bus.c_req & ~w_d_gnt;
    end

    // grant and stall toward the requesters and the hazard unit
    always_comb begin
        bus.c_gnt      = w_c_gnt;
        bus.d_gnt      = w_d_gnt;
        bus.core_stall = bus.c_req & ~w_c_gnt;
    end

    // starvation counter: counts consecutive denials, cleared on grant or idle
    always_comb begin
        w_wait_nxt = '0;
        if (bus.d_req && !w_d_gnt) begin
            if (r_wait_cnt == LP_MAX) begin
                w_wait_nxt = r_wait_cnt;
            end else begin
                w_wait_nxt = r_wait_cnt + CW'(1);
            end
        end
    end

    // starvation counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // RAM mux: granted port drives the RAM, otherwise all zero
    always_comb begin
        w_we   = 1'b0;
        w_addr = '0;
        w_din  = '0;
        w_ubhw = '0;
        if (w_c_gnt) begin
            w_we   = bus.c_we;
            w_addr = bus.c_addr;
            w_din  = bus.c_wdata;
            w_ubhw = bus.c_ubhw;
        end else if (w_d_gnt) begin
            w_we   = bus.d_we;
            w_addr = bus.d_addr;
            w_din  = bus.d_wdata;
            w_ubhw = bus.d_ubhw;
        end
    end

    // RAM outputs; writes are suppressed while reset is held
    always_comb begin
        bus.ram_we   = w_we & ~rst;
        bus.ram_addr = w_addr;
        bus.ram_din  = w_din;
        bus.ram_ubhw = w_ubhw;
    end

    // owner state register: who issued last cycle's read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    // owner next state: a granted read claims the return slot
    always_comb begin
        w_owner_nxt = OWN_NONE;
        if (w_c_gnt && !bus.c_we) begin
            w_owner_nxt = OWN_CORE;
        end else if (w_d_gnt && !bus.d_we) begin
            w_owner_nxt = OWN_DBG;
        end
    end

    // owner outputs: route RAM read data to its owner, zero otherwise
    always_comb begin
        bus.c_rvalid = 1'b0;
        bus.d_rvalid = 1'b0;
        bus.c_rdata  = 32'h0;
        bus.d_rdata  = 32'h0;
        unique case (r_owner)
            OWN_CORE: begin
                bus.c_rvalid = 1'b1;
                bus.c_rdata  = bus.ram_dout;
            end
            OWN_DBG: begin
                bus.d_rvalid = 1'b1;
                bus.d_rdata  = bus.ram_dout;
            end
            default: begin
                bus.c_rvalid = 1'b0;
                bus.d_rvalid = 1'b0;
            end
        endcase
    end
endmodule
